// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out receive controller:
// FSM state encoding and the counter-width helper.
package sipo_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    typedef enum logic {
        StIdle  = ST_IDLE,
        StShift = ST_SHIFT
    } state_e;

    // Ceiling log2; returns at least 1 so a counter never collapses to zero bits.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sipo_shift_en.sv
// WIDTH-bit shift register with enable and selectable shift direction.
// sr_next is the value the register takes at the coming edge.
module sipo_shift_en #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             si,
    output logic [WIDTH-1:0] sr,
    output logic [WIDTH-1:0] sr_next
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] sr_shift;

    always_comb begin
        sr_shift = sr_q;
        if (MSB_FIRST) begin
            sr_shift = {sr_q[WIDTH-2:0], si};
        end else begin
            sr_shift = {si, sr_q[WIDTH-1:1]};
        end
        sr_d = en ? sr_shift : sr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sr      = sr_q;
    assign sr_next = sr_d;

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Framing controller for a serial-to-parallel receiver: bit counter, FSM,
// holding register with valid/ready handshake, sticky overrun. Define
// SIPO_PARITY_EN to append an even-parity bit to each frame.
module sipo_rx_ctrl
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          si,
    input  logic                          si_valid,
    input  logic                          start,
    output logic [WIDTH-1:0]              word_out,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic                          busy,
    output logic [clog2(WIDTH+1)-1:0]     bit_cnt,
    output logic                          overrun,
    input  logic                          ovr_clr,
    output logic                          parity_err
);

    localparam int unsigned CW = clog2(WIDTH + 1);
`ifdef SIPO_PARITY_EN
    localparam int unsigned FRAME = WIDTH + 1;
`else
    localparam int unsigned FRAME = WIDTH;
`endif
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             perr_q, perr_d;

    logic             shift_en;
    logic             complete;
    logic [WIDTH-1:0] sr_word;
    logic [WIDTH-1:0] sr_next;
    logic             new_perr;

`ifdef SIPO_PARITY_EN
    localparam logic [CW-1:0] PAR_CNT = CW'(WIDTH);
    // The parity slot is not shifted; a start-qualified bit is always data.
    assign shift_en = si_valid && (start || (bit_cnt_q != PAR_CNT));
    assign new_perr = (^sr_word) ^ si;
`else
    assign shift_en = si_valid;
    assign new_perr = 1'b0;
`endif

    assign complete = si_valid && !start && (bit_cnt_q == LAST_CNT);

    sipo_shift_en #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .en      (shift_en),
        .si      (si),
        .sr      (sr_word),
        .sr_next (sr_next)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        if (start && si_valid) begin
            state_d   = StShift;
            bit_cnt_d = CW'(1);
        end else if (start) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
        end else if (complete) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
        end else if (si_valid) begin
            state_d   = StShift;
            bit_cnt_d = bit_cnt_q + CW'(1);
        end
    end

    // A completed word loads only if the holding slot is free or being emptied.
    always_comb begin
        word_d    = word_q;
        valid_d   = valid_q;
        perr_d    = perr_q;
        overrun_d = overrun_q;
        if (ovr_clr) begin
            overrun_d = 1'b0;
        end
        if (complete && (!valid_q || word_ready)) begin
            word_d  = sr_next;
            perr_d  = new_perr;
            valid_d = 1'b1;
        end else if (complete) begin
            overrun_d = 1'b1;
        end else if (valid_q && word_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            perr_q    <= perr_d;
        end
    end

    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign busy       = (state_q == StShift);
    assign bit_cnt    = bit_cnt_q;
    assign overrun    = overrun_q;
    assign parity_err = perr_q;

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Directed bench for sipo_rx_ctrl (WIDTH=4, MSB first); the parity scenario
// runs when SIPO_PARITY_EN is defined.
module tb_sipo_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       si = 1'b0;
    logic       si_valid = 1'b0;
    logic       start = 1'b0;
    logic       word_ready = 1'b0;
    logic       ovr_clr = 1'b0;
    logic [3:0] word_out;
    logic       word_valid;
    logic       busy;
    logic [2:0] bit_cnt;
    logic       overrun;
    logic       parity_err;

    int errors = 0;
    int checks = 0;

    sipo_rx_ctrl #(
        .WIDTH     (4),
        .MSB_FIRST (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .si         (si),
        .si_valid   (si_valid),
        .start      (start),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy),
        .bit_cnt    (bit_cnt),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        si       = b;
        si_valid = 1'b1;
        tick();
    endtask

    task automatic idle(input int n);
        si_valid = 1'b0;
        si       = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        #3;
        checks++; if (word_out !== 4'b0000) begin $display("FAIL reset_word_out got %b want 0000", word_out); errors++; end
        checks++; if (word_valid !== 1'b0) begin $display("FAIL reset_word_valid got %b want 0", word_valid); errors++; end
        checks++; if (bit_cnt !== 3'd0) begin $display("FAIL reset_bit_cnt got %0d want 0", bit_cnt); errors++; end
        checks++; if (busy !== 1'b0) begin $display("FAIL reset_busy got %b want 0", busy); errors++; end
        checks++; if (overrun !== 1'b0) begin $display("FAIL reset_overrun got %b want 0", overrun); errors++; end
        checks++; if (parity_err !== 1'b0) begin $display("FAIL reset_parity_err got %b want 0", parity_err); errors++; end
        #9;
        rst = 1'b1;
        idle(1);
    endtask

    task automatic test_single_word();
        logic [3:0] bits;
        logic [2:0] exp_cnt [4];
        bits       = 4'b1101;
        exp_cnt    = '{3'd1, 3'd2, 3'd3, 3'd0};
        word_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_bit(bits[3-i]);
            checks++;
            if (bit_cnt !== exp_cnt[i]) begin
                $display("FAIL single_bit_cnt[%0d] got %0d want %0d", i, bit_cnt, exp_cnt[i]);
                errors++;
            end
            if (i == 2) begin
                checks++; if (busy !== 1'b1) begin $display("FAIL single_busy got %b want 1", busy); errors++; end
                checks++; if (word_valid !== 1'b0) begin $display("FAIL single_early_valid got %b want 0", word_valid); errors++; end
            end
        end
        checks++; if (word_out !== 4'b1101) begin $display("FAIL single_word_out got %b want 1101", word_out); errors++; end
        checks++; if (word_valid !== 1'b1) begin $display("FAIL single_valid got %b want 1", word_valid); errors++; end
        checks++; if (busy !== 1'b0) begin $display("FAIL single_busy_done got %b want 0", busy); errors++; end
        idle(1);
        checks++; if (word_valid !== 1'b0) begin $display("FAIL single_valid_pulse got %b want 0", word_valid); errors++; end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bits;
        bits       = 8'b1101_0110;
        word_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_bit(bits[7-i]);
            if (i == 3) begin
                checks++; if (word_out !== 4'b1101) begin $display("FAIL b2b_word0 got %b want 1101", word_out); errors++; end
                checks++; if (word_valid !== 1'b1) begin $display("FAIL b2b_valid0 got %b want 1", word_valid); errors++; end
            end
            if (i == 4) begin
                checks++; if (word_valid !== 1'b0) begin $display("FAIL b2b_consumed got %b want 0", word_valid); errors++; end
                checks++; if (bit_cnt !== 3'd1) begin $display("FAIL b2b_cnt got %0d want 1", bit_cnt); errors++; end
            end
        end
        checks++; if (word_out !== 4'b0110) begin $display("FAIL b2b_word1 got %b want 0110", word_out); errors++; end
        checks++; if (word_valid !== 1'b1) begin $display("FAIL b2b_valid1 got %b want 1", word_valid); errors++; end
        checks++; if (overrun !== 1'b0) begin $display("FAIL b2b_overrun got %b want 0", overrun); errors++; end
        idle(1);
    endtask

    task automatic test_overrun();
        logic [7:0] bits;
        bits       = 8'b1010_0011;
        word_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            // Clear requested on the dropping edge: the set must win.
            if (i == 7) ovr_clr = 1'b1;
            drive_bit(bits[7-i]);
            ovr_clr = 1'b0;
            if (i == 3) begin
                checks++; if (word_out !== 4'b1010) begin $display("FAIL ovr_word0 got %b want 1010", word_out); errors++; end
                checks++; if (overrun !== 1'b0) begin $display("FAIL ovr_early got %b want 0", overrun); errors++; end
            end
        end
        checks++; if (overrun !== 1'b1) begin $display("FAIL ovr_set got %b want 1", overrun); errors++; end
        checks++; if (word_out !== 4'b1010) begin $display("FAIL ovr_hold_word got %b want 1010", word_out); errors++; end
        checks++; if (word_valid !== 1'b1) begin $display("FAIL ovr_hold_valid got %b want 1", word_valid); errors++; end
        ovr_clr = 1'b1;
        idle(1);
        ovr_clr = 1'b0;
        checks++; if (overrun !== 1'b0) begin $display("FAIL ovr_clear got %b want 0", overrun); errors++; end
        checks++; if (word_out !== 4'b1010) begin $display("FAIL ovr_word_after_clr got %b want 1010", word_out); errors++; end
        word_ready = 1'b1;
        idle(1);
        checks++; if (word_valid !== 1'b0) begin $display("FAIL ovr_consume got %b want 0", word_valid); errors++; end
    endtask

    task automatic test_start();
        word_ready = 1'b1;
        drive_bit(1'b1);
        drive_bit(1'b1);
        checks++; if (bit_cnt !== 3'd2) begin $display("FAIL start_pre_cnt got %0d want 2", bit_cnt); errors++; end
        start = 1'b1;
        drive_bit(1'b0);
        start = 1'b0;
        checks++; if (bit_cnt !== 3'd1) begin $display("FAIL start_cnt got %0d want 1", bit_cnt); errors++; end
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        checks++; if (word_out !== 4'b0101) begin $display("FAIL start_word got %b want 0101", word_out); errors++; end
        checks++; if (word_valid !== 1'b1) begin $display("FAIL start_valid got %b want 1", word_valid); errors++; end
        word_ready = 1'b0;
        drive_bit(1'b1);
        si_valid = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (bit_cnt !== 3'd0) begin $display("FAIL start_alone_cnt got %0d want 0", bit_cnt); errors++; end
        checks++; if (busy !== 1'b0) begin $display("FAIL start_alone_busy got %b want 0", busy); errors++; end
        checks++; if (word_valid !== 1'b1) begin $display("FAIL start_keeps_valid got %b want 1", word_valid); errors++; end
        checks++; if (word_out !== 4'b0101) begin $display("FAIL start_keeps_word got %b want 0101", word_out); errors++; end
        word_ready = 1'b1;
        idle(1);
    endtask

    task automatic test_reset_mid_frame();
        word_ready = 1'b0;
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        si_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checks++; if (word_out !== 4'b0000) begin $display("FAIL rstmid_word got %b want 0000", word_out); errors++; end
        checks++; if (word_valid !== 1'b0) begin $display("FAIL rstmid_valid got %b want 0", word_valid); errors++; end
        checks++; if (bit_cnt !== 3'd0) begin $display("FAIL rstmid_cnt got %0d want 0", bit_cnt); errors++; end
        checks++; if (busy !== 1'b0) begin $display("FAIL rstmid_busy got %b want 0", busy); errors++; end
        #1;
        rst        = 1'b1;
        word_ready = 1'b1;
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        checks++; if (word_out !== 4'b1001) begin $display("FAIL rstmid_word_after got %b want 1001", word_out); errors++; end
        checks++; if (word_valid !== 1'b1) begin $display("FAIL rstmid_valid_after got %b want 1", word_valid); errors++; end
        idle(1);
    endtask

`ifdef SIPO_PARITY_EN
    task automatic test_parity();
        word_ready = 1'b1;
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        checks++; if (bit_cnt !== 3'd4) begin $display("FAIL par_cnt got %0d want 4", bit_cnt); errors++; end
        checks++; if (word_valid !== 1'b0) begin $display("FAIL par_early got %b want 0", word_valid); errors++; end
        drive_bit(1'b1);
        checks++; if (word_out !== 4'b1101) begin $display("FAIL par_word0 got %b want 1101", word_out); errors++; end
        checks++; if (parity_err !== 1'b0) begin $display("FAIL par_ok got %b want 0", parity_err); errors++; end
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        checks++; if (word_out !== 4'b1101) begin $display("FAIL par_word1 got %b want 1101", word_out); errors++; end
        checks++; if (parity_err !== 1'b1) begin $display("FAIL par_bad got %b want 1", parity_err); errors++; end
        checks++; if (word_valid !== 1'b1) begin $display("FAIL par_valid got %b want 1", word_valid); errors++; end
        idle(1);
    endtask
`endif

    initial begin
        test_reset();
`ifdef SIPO_PARITY_EN
        test_parity();
`else
        test_single_word();
        test_back_to_back();
        test_overrun();
        test_start();
        test_reset_mid_frame();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
